// File: rtl/micro_sequencer_if.sv
// Host/datapath-facing signal bundle of the micro-sequencer.
// Handshake: a wait-flagged microword retires on the first clock edge with done=1 and stall=0 (and no halt).
interface micro_sequencer_if #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 5,
    parameter int OPC_W  = 2,
    parameter int CNT_W  = 8
);
    localparam int CTRL_W = WORD_W - 4 - ADDR_W;

    logic              start;
    logic              halt;
    logic              stall;
    logic              done;
    logic [OPC_W-1:0]  opcode;
    logic [CNT_W-1:0]  iter_count;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic [CTRL_W-1:0] ctrl;
    logic [ADDR_W-1:0] upc;
    logic              busy;
    logic              instr_done;
    logic              state_dbg;

    modport master (
        output start, halt, stall, done, opcode, iter_count, wr_en, wr_addr, wr_data,
        input  ctrl, upc, busy, instr_done, state_dbg
    );

    modport slave (
        input  start, halt, stall, done, opcode, iter_count, wr_en, wr_addr, wr_data,
        output ctrl, upc, busy, instr_done, state_dbg
    );
endinterface

// File: rtl/micro_sequencer.sv
// Writable micro-programmed control unit: control store, micro-PC, next-address logic
// (sequence/jump/loop/dispatch/fetch) and done-wait, driving per-cycle datapath control bits.
module micro_sequencer #(
    parameter int    WORD_W     = 16,
    parameter int    ADDR_W     = 5,
    parameter int    OPC_W      = 2,
    parameter int    DISP_SHIFT = 3,
    parameter int    CNT_W      = 8,
    parameter string INIT_FILE  = ""
) (
    input logic               clk,
    input logic               rst,
    micro_sequencer_if.slave  bus
);
    localparam int CTRL_W = WORD_W - 4 - ADDR_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int DISP_W = ADDR_W + OPC_W + DISP_SHIFT;

    localparam logic [2:0] OP_NEXT     = 3'b000;
    localparam logic [2:0] OP_JUMP     = 3'b001;
    localparam logic [2:0] OP_LOOP     = 3'b010;
    localparam logic [2:0] OP_DISPATCH = 3'b011;
    localparam logic [2:0] OP_FETCH    = 3'b100;

    if (CTRL_W < 1) begin : g_bad_width
        $error("micro_sequencer: WORD_W-4-ADDR_W must be at least 1");
    end
    if (INIT_FILE != "") begin : g_no_preload
        $warning("micro_sequencer: INIT_FILE preload unavailable; load microcode through the write port");
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [WORD_W-1:0] store [DEPTH];
    logic [WORD_W-1:0] uword;
    logic [ADDR_W-1:0] upc;
    logic [CNT_W-1:0]  loop_cnt;
    logic [CNT_W-1:0]  loop_cnt_d;
    logic [ADDR_W-1:0] next_addr;
    logic [DISP_W-1:0] disp_full;
    logic [ADDR_W-1:0] disp_addr;
    logic [2:0]        op;
    logic              wait_f;
    logic [CTRL_W-1:0] ctrl_f;
    logic [ADDR_W-1:0] target;
    logic              advance;
    logic              launch;

    assign op     = uword[WORD_W-1 -: 3];
    assign wait_f = uword[WORD_W-4];
    assign ctrl_f = uword[ADDR_W +: CTRL_W];
    assign target = uword[ADDR_W-1:0];

    assign disp_full = DISP_W'(bus.opcode) << DISP_SHIFT;
    assign disp_addr = disp_full[ADDR_W-1:0];

    assign launch  = (state_q == IDLE) && bus.start && !bus.halt;
    assign advance = (state_q == RUN) && !bus.halt && !bus.stall && !(wait_f && !bus.done);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start && !bus.halt) state_d = RUN;
            RUN:     if (bus.halt) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Opcodes 101-111 fall through to the sequential default.
    always_comb begin
        next_addr  = upc + ADDR_W'(1);
        loop_cnt_d = loop_cnt;
        case (op)
            OP_JUMP: next_addr = target;
            OP_LOOP: begin
                if (loop_cnt != '0) begin
                    next_addr  = target;
                    loop_cnt_d = loop_cnt - CNT_W'(1);
                end
            end
            OP_DISPATCH: begin
                next_addr  = disp_addr;
                loop_cnt_d = bus.iter_count;
            end
            OP_FETCH: next_addr = '0;
            default:  next_addr = upc + ADDR_W'(1);
        endcase
    end

    // uword mirrors store[upc]; a same-cycle write to the fetched address yields the old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upc      <= '0;
            uword    <= '0;
            loop_cnt <= '0;
        end else if (launch) begin
            upc   <= '0;
            uword <= store[0];
        end else if (advance) begin
            upc      <= next_addr;
            uword    <= store[next_addr];
            loop_cnt <= loop_cnt_d;
        end
    end

    // The store has no reset so microcode survives rst.
    always_ff @(posedge clk) begin
        if (bus.wr_en) store[bus.wr_addr] <= bus.wr_data;
    end

    assign bus.ctrl       = (state_q == RUN) ? ctrl_f : '0;
    assign bus.upc        = upc;
    assign bus.busy       = (state_q == RUN);
    assign bus.instr_done = advance && (op == OP_FETCH);
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: hand-computed expectations checked with immediate assertions.
module tb_micro_sequencer;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 5;
  localparam int OPC_W  = 2;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  // clock/reset block
  always #5 clk = ~clk;

  micro_sequencer_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W), .CNT_W(CNT_W)) bus ();

  micro_sequencer #(
    .WORD_W(WORD_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W), .DISP_SHIFT(3), .CNT_W(CNT_W), .INIT_FILE("")
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [15:0] mw(input logic [2:0] op, input logic w,
                                     input logic [6:0] c, input logic [4:0] t);
    return {op, w, c, t};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic halt_run();
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [4:0] e_upc, input logic [6:0] e_ctrl,
                         input logic e_busy, input logic e_done);
    chk({tag, ".upc"},  32'(bus.upc),        32'(e_upc));
    chk({tag, ".ctrl"}, 32'(bus.ctrl),       32'(e_ctrl));
    chk({tag, ".busy"}, 32'(bus.busy),       32'(e_busy));
    chk({tag, ".idone"}, 32'(bus.instr_done), 32'(e_done));
  endtask

  function automatic logic [6:0] t3_ctrl(input int a);
    case (a)
      0:       return 7'h01;
      16:      return 7'h10;
      17:      return 7'h17;
      default: return 7'h18;
    endcase
  endfunction

  initial begin
    int exp_upc[11] = '{0, 16, 17, 16, 17, 16, 17, 16, 17, 18, 0};

    bus.start = 1'b0; bus.halt = 1'b0; bus.stall = 1'b0; bus.done = 1'b0;
    bus.opcode = '0; bus.iter_count = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;

    #12;
    chk_out("reset", 5'd0, 7'h00, 1'b0, 1'b0);
    chk("reset.state", 32'(bus.state_dbg), 32'd0);
    rst = 1'b0;
    tick();

    // T2: plain sequence with a FETCH back to 0
    wr(5'd0, mw(3'b000, 1'b0, 7'h11, 5'd0));
    wr(5'd1, mw(3'b000, 1'b0, 7'h22, 5'd0));
    wr(5'd2, mw(3'b100, 1'b0, 7'h44, 5'd0));
    chk_out("t2.idle", 5'd0, 7'h00, 1'b0, 1'b0);
    pulse_start();
    chk_out("t2.w0", 5'd0, 7'h11, 1'b1, 1'b0);
    tick();
    chk_out("t2.w1", 5'd1, 7'h22, 1'b1, 1'b0);
    tick();
    chk_out("t2.w2", 5'd2, 7'h44, 1'b1, 1'b1);
    tick();
    chk_out("t2.wrap", 5'd0, 7'h11, 1'b1, 1'b0);
    halt_run();
    chk_out("t2.halted", 5'd0, 7'h00, 1'b0, 1'b0);

    // halt wins over start in IDLE
    bus.halt = 1'b1; bus.start = 1'b1;
    tick();
    bus.halt = 1'b0; bus.start = 1'b0;
    chk("hs.busy", 32'(bus.busy), 32'd0);
    chk("hs.ctrl", 32'(bus.ctrl), 32'd0);

    // T3: dispatch to 16, loop body 4 passes
    wr(5'd0,  mw(3'b011, 1'b0, 7'h01, 5'd0));
    wr(5'd16, mw(3'b000, 1'b0, 7'h10, 5'd0));
    wr(5'd17, mw(3'b010, 1'b0, 7'h17, 5'd16));
    wr(5'd18, mw(3'b100, 1'b0, 7'h18, 5'd0));
    bus.opcode = 2'd2;
    bus.iter_count = 8'd3;
    pulse_start();
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("t3.upc%0d", i), 32'(bus.upc), 32'(exp_upc[i]));
      chk($sformatf("t3.ctrl%0d", i), 32'(bus.ctrl), 32'(t3_ctrl(exp_upc[i])));
      chk($sformatf("t3.idone%0d", i), 32'(bus.instr_done), (i == 9) ? 32'd1 : 32'd0);
      tick();
    end
    halt_run();

    // T4: wait on word 16, then wait overlapped with stall
    wr(5'd16, mw(3'b000, 1'b1, 7'h10, 5'd0));
    bus.done = 1'b0;
    pulse_start();
    chk("t4.start", 32'(bus.upc), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk_out($sformatf("t4.hold%0d", i), 5'd16, 7'h10, 1'b1, 1'b0);
      tick();
    end
    chk("t4.held", 32'(bus.upc), 32'd16);
    bus.done = 1'b1;
    chk("t4.rel.idone", 32'(bus.instr_done), 32'd0);
    tick();
    bus.done = 1'b0;
    chk("t4.adv", 32'(bus.upc), 32'd17);
    tick();
    chk("t4.loopback", 32'(bus.upc), 32'd16);
    for (int i = 0; i < 4; i++) begin
      bus.stall = i[0];
      tick();
      chk($sformatf("t4.sthold%0d", i), 32'(bus.upc), 32'd16);
    end
    bus.done = 1'b1; bus.stall = 1'b1;
    tick();
    chk("t4.done_stalled", 32'(bus.upc), 32'd16);
    chk("t4.done_stalled.ctrl", 32'(bus.ctrl), 32'h10);
    bus.stall = 1'b0;
    tick();
    bus.done = 1'b0;
    chk("t4.adv2", 32'(bus.upc), 32'd17);

    // T5: halt at upc=17, restart at 0
    halt_run();
    chk_out("t5.halted", 5'd17, 7'h00, 1'b0, 1'b0);
    pulse_start();
    chk_out("t5.restart", 5'd0, 7'h01, 1'b1, 1'b0);
    halt_run();

    // T6: write to address 1 on the same edge it is fetched
    wr(5'd0, mw(3'b000, 1'b0, 7'h11, 5'd0));
    wr(5'd1, mw(3'b000, 1'b0, 7'h22, 5'd0));
    wr(5'd2, mw(3'b100, 1'b0, 7'h44, 5'd0));
    pulse_start();
    chk("t6.w0", 32'(bus.ctrl), 32'h11);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd1; bus.wr_data = mw(3'b000, 1'b0, 7'h55, 5'd0);
    tick();
    bus.wr_en = 1'b0;
    chk_out("t6.old", 5'd1, 7'h22, 1'b1, 1'b0);
    tick();
    chk_out("t6.w2", 5'd2, 7'h44, 1'b1, 1'b1);
    tick();
    chk("t6.w0b", 32'(bus.upc), 32'd0);
    tick();
    chk_out("t6.new", 5'd1, 7'h55, 1'b1, 1'b0);

    // T1: asynchronous reset mid-run, store preserved
    #2;
    rst = 1'b1;
    #1;
    chk_out("t1.rst", 5'd0, 7'h00, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    pulse_start();
    chk_out("t1.rb0", 5'd0, 7'h11, 1'b1, 1'b0);
    tick();
    chk_out("t1.rb1", 5'd1, 7'h55, 1'b1, 1'b0);
    halt_run();

    // wrap DEPTH-1 -> 0 through an unassigned opcode, entered by JUMP
    wr(5'd0,  mw(3'b001, 1'b0, 7'h30, 5'd31));
    wr(5'd31, mw(3'b101, 1'b0, 7'h31, 5'd5));
    pulse_start();
    chk_out("wrap.w0", 5'd0, 7'h30, 1'b1, 1'b0);
    tick();
    chk_out("wrap.w31", 5'd31, 7'h31, 1'b1, 1'b0);
    tick();
    chk_out("wrap.back", 5'd0, 7'h30, 1'b1, 1'b0);
    halt_run();

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
